multi_mode_timer: RTL and testbench

Parametrised multi-mode countdown timer for the vending machine controller. It holds one reload value per mode, and those values are programmable at runtime. It adds a tick prescaler, pause and cancel controls, and explicit start strobes in place of start-on-mode-change. Expiry is reported both as a one-cycle timeout pulse and as a sticky expired flag, which the main FSM consumes.

---
 rtl/vm_timer_pkg.sv | 24 ++
 rtl/timer_prescaler.sv | 31 +++
 rtl/multi_mode_timer.sv | 132 +++++++++++++
 tb/tb_multi_mode_timer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_timer_pkg.sv
// Shared types and constants for the vending machine multi-mode timer.
package vm_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_t;

    localparam logic [1:0] MODE_WAIT_SELECT    = 2'd0;
    localparam logic [1:0] MODE_PRODUCT_RETURN = 2'd1;
    localparam logic [1:0] MODE_CHANGE_RETURN  = 2'd2;

    localparam logic [7:0] RELOAD_WAIT_SELECT    = 8'd30;
    localparam logic [7:0] RELOAD_PRODUCT_RETURN = 8'd5;
    localparam logic [7:0] RELOAD_CHANGE_RETURN  = 8'd5;
    localparam logic [7:0] RELOAD_SPARE          = 8'd0;

    // Mode i occupies bits [i*8 +: 8]; mode 0 in the least significant byte.
    localparam logic [31:0] RELOAD_INIT_DEFAULT = {RELOAD_SPARE, RELOAD_CHANGE_RETURN,
                                                   RELOAD_PRODUCT_RETURN, RELOAD_WAIT_SELECT};

endpackage

// File: rtl/timer_prescaler.sv
// Count-tick prescaler: emits one tick every PRESCALE_DIV enabled cycles.
// The phase is held while enable is low, so a paused timer resumes mid-period.
module timer_prescaler #(
    parameter int PRESCALE_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            PW   = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE_DIV - 1);

    logic [PW-1:0] phase_q;

    assign tick = enable && (phase_q == LAST);

    // Phase counter: cleared on (re)start, advances only while enabled, wraps at LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else if (clear) begin
            phase_q <= '0;
        end else if (enable) begin
            phase_q <= (phase_q == LAST) ? '0 : phase_q + 1'b1;
        end
    end

endmodule

// File: rtl/multi_mode_timer.sv
// Multi-mode countdown timer with runtime-programmable reload values,
// prescaled ticks, pause/cancel control and explicit start strobes.
// Expiry is reported as a one-cycle timeout_pulse plus a sticky expired flag.
module multi_mode_timer
    import vm_timer_pkg::*;
#(
    parameter int                         CNT_W        = 8,
    parameter int                         NUM_MODES    = 4,
    parameter int                         MODE_W       = 2,
    parameter int                         PRESCALE_DIV = 1,
    parameter logic [NUM_MODES*CNT_W-1:0] RELOAD_INIT  = (NUM_MODES*CNT_W)'(RELOAD_INIT_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MODE_W-1:0] start_mode,
    input  logic              pause,
    input  logic              cancel,
    input  logic              cfg_we,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [CNT_W-1:0]  cfg_value,
    output logic [CNT_W-1:0]  count_o,
    output logic [MODE_W-1:0] mode_o,
    output logic              busy,
    output logic              expired,
    output logic              timeout_pulse,
    output logic              err_pulse
);

    localparam logic [MODE_W:0] NUM_MODES_W = (MODE_W + 1)'(NUM_MODES);

    timer_state_t      state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              timeout_d;
    logic              busy_q, expired_q, timeout_q, err_q;
    logic [CNT_W-1:0]  reload_q [NUM_MODES];

    logic start_ok, start_bad, cfg_ok, cfg_bad;
    logic presc_clear, presc_en, tick;

    assign start_ok  = start  && ({1'b0, start_mode} <  NUM_MODES_W);
    assign start_bad = start  && ({1'b0, start_mode} >= NUM_MODES_W);
    assign cfg_ok    = cfg_we && ({1'b0, cfg_mode}   <  NUM_MODES_W);
    assign cfg_bad   = cfg_we && ({1'b0, cfg_mode}   >= NUM_MODES_W);

    // The prescaler only advances in a counting cycle: active, unpaused, not
    // overridden by start/cancel, and with a nonzero count left.
    assign presc_clear = start_ok || cancel;
    assign presc_en    = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && !pause &&
                         !start_ok && !cancel && (count_q != '0);

    timer_prescaler #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (presc_clear),
        .enable(presc_en),
        .tick  (tick)
    );

    // Reload registers: restored on reset, written by valid cfg_we. A start in
    // the same cycle reads the value held before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_MODES; i++) begin
                reload_q[i] <= RELOAD_INIT[i*CNT_W +: CNT_W];
            end
        end else if (cfg_ok) begin
            reload_q[cfg_mode] <= cfg_value;
        end
    end

    // Next-state logic in priority order start > cancel > pause > counting.
    // Releasing pause counts in the same cycle, so a pause costs exactly its length.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mode_d    = mode_q;
        timeout_d = 1'b0;
        if (start_ok) begin
            count_d = reload_q[start_mode];
            mode_d  = start_mode;
            state_d = ST_RUN;
        end else if (cancel) begin
            count_d = '0;
            state_d = ST_IDLE;
        end else if ((state_q == ST_RUN) || (state_q == ST_PAUSE)) begin
            if (pause) begin
                state_d = ST_PAUSE;
            end else if (count_q == '0) begin
                state_d   = ST_EXPIRED;
                timeout_d = 1'b1;
            end else begin
                state_d = ST_RUN;
                if (tick) begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            mode_q    <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            busy_q    <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
            expired_q <= (state_d == ST_EXPIRED);
            timeout_q <= timeout_d;
            err_q     <= start_bad || cfg_bad;
        end
    end

    assign count_o       = count_q;
    assign mode_o        = mode_q;
    assign busy          = busy_q;
    assign expired       = expired_q;
    assign timeout_pulse = timeout_q;
    assign err_pulse     = err_q;

endmodule

// File: tb/tb_multi_mode_timer.sv
// Self-checking bench for multi_mode_timer. Two instances share clk/rst:
// dut_a (3 modes, divide-by-1) and dut_b (4 modes, divide-by-4).
// Observations are packed as {mode, count, busy, expired, timeout, err}.
module tb_multi_mode_timer;
    import vm_timer_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic       a_start, a_pause, a_cancel, a_cfg_we;
    logic [1:0] a_start_mode, a_cfg_mode;
    logic [7:0] a_cfg_value, a_count;
    logic [1:0] a_mode;
    logic       a_busy, a_expired, a_timeout, a_err;

    logic       b_start, b_pause, b_cancel, b_cfg_we;
    logic [1:0] b_start_mode, b_cfg_mode;
    logic [7:0] b_cfg_value, b_count;
    logic [1:0] b_mode;
    logic       b_busy, b_expired, b_timeout, b_err;

    logic [13:0] exp_q [$];
    logic [13:0] e, o;
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    multi_mode_timer #(
        .CNT_W(8), .NUM_MODES(3), .MODE_W(2), .PRESCALE_DIV(1), .RELOAD_INIT(24'h05_05_1E)
    ) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .start_mode(a_start_mode), .pause(a_pause),
        .cancel(a_cancel), .cfg_we(a_cfg_we), .cfg_mode(a_cfg_mode), .cfg_value(a_cfg_value),
        .count_o(a_count), .mode_o(a_mode), .busy(a_busy), .expired(a_expired),
        .timeout_pulse(a_timeout), .err_pulse(a_err)
    );

    multi_mode_timer #(
        .CNT_W(8), .NUM_MODES(4), .MODE_W(2), .PRESCALE_DIV(4), .RELOAD_INIT(32'h0005_051E)
    ) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .start_mode(b_start_mode), .pause(b_pause),
        .cancel(b_cancel), .cfg_we(b_cfg_we), .cfg_mode(b_cfg_mode), .cfg_value(b_cfg_value),
        .count_o(b_count), .mode_o(b_mode), .busy(b_busy), .expired(b_expired),
        .timeout_pulse(b_timeout), .err_pulse(b_err)
    );

    function automatic logic [13:0] obs_a();
        return {a_mode, a_count, a_busy, a_expired, a_timeout, a_err};
    endfunction

    function automatic logic [13:0] obs_b();
        return {b_mode, b_count, b_busy, b_expired, b_timeout, b_err};
    endfunction

    // Expected observation k edges after a start of mode m with reload n, divider div.
    function automatic logic [13:0] model(logic [1:0] m, int n, int div, int k);
        if (k <= n * div)          return {m, 8'(n - k / div), 4'b1000};
        else if (k == n * div + 1) return {m, 8'd0, 4'b0110};
        else                       return {m, 8'd0, 4'b0100};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        exp_q.push_back(14'h0);
        exp_q.push_back(14'h0);
        e = exp_q.pop_front(); o = obs_a(); checks++;
        if (o !== e) $display("FAIL reset_a got=%h want=%h", o, e); else passed++;
        e = exp_q.pop_front(); o = obs_b(); checks++;
        if (o !== e) $display("FAIL reset_b got=%h want=%h", o, e); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc();
        exp_q.push_back(14'h0);
        e = exp_q.pop_front(); o = obs_a(); checks++;
        if (o !== e) $display("FAIL reset_release got=%h want=%h", o, e); else passed++;
    endtask

    task automatic test_countdown();
        a_start = 1'b1; a_start_mode = MODE_PRODUCT_RETURN;
        for (int k = 0; k <= 8; k++) exp_q.push_back(model(MODE_PRODUCT_RETURN, 5, 1, k));
        for (int k = 0; k <= 8; k++) begin
            cyc();
            a_start = 1'b0;
            e = exp_q.pop_front(); o = obs_a(); checks++;
            if (o !== e) $display("FAIL countdown k=%0d got=%h want=%h", k, o, e); else passed++;
        end
    endtask

    task automatic test_prescaler();
        b_cfg_we = 1'b1; b_cfg_mode = 2'd3; b_cfg_value = 8'd2;
        exp_q.push_back(14'h0);
        cyc();
        b_cfg_we = 1'b0;
        e = exp_q.pop_front(); o = obs_b(); checks++;
        if (o !== e) $display("FAIL presc_cfg got=%h want=%h", o, e); else passed++;
        b_start = 1'b1; b_start_mode = 2'd3;
        for (int k = 0; k <= 11; k++) exp_q.push_back(model(2'd3, 2, 4, k));
        for (int k = 0; k <= 11; k++) begin
            cyc();
            b_start = 1'b0;
            e = exp_q.pop_front(); o = obs_b(); checks++;
            if (o !== e) $display("FAIL presc k=%0d got=%h want=%h", k, o, e); else passed++;
        end
    endtask

    task automatic test_pause();
        a_start = 1'b1; a_start_mode = MODE_WAIT_SELECT;
        // Pause is sampled at edges 11..20, holding count at 20 for ten cycles.
        for (int k = 0; k <= 43; k++)
            exp_q.push_back(model(MODE_WAIT_SELECT, 30, 1, (k <= 10) ? k : (k <= 20) ? 10 : k - 10));
        for (int k = 0; k <= 43; k++) begin
            cyc();
            a_start = 1'b0;
            e = exp_q.pop_front(); o = obs_a(); checks++;
            if (o !== e) $display("FAIL pause k=%0d got=%h want=%h", k, o, e); else passed++;
            if (k == 10) a_pause = 1'b1;
            if (k == 20) a_pause = 1'b0;
        end
    endtask

    task automatic test_cfg_same_cycle();
        a_cfg_we = 1'b1; a_cfg_mode = MODE_CHANGE_RETURN; a_cfg_value = 8'd3;
        a_start = 1'b1; a_start_mode = MODE_CHANGE_RETURN;
        for (int k = 0; k <= 1; k++) exp_q.push_back(model(MODE_CHANGE_RETURN, 5, 1, k));
        for (int k = 0; k <= 1; k++) begin
            cyc();
            a_cfg_we = 1'b0; a_start = 1'b0;
            e = exp_q.pop_front(); o = obs_a(); checks++;
            if (o !== e) $display("FAIL cfg_old k=%0d got=%h want=%h", k, o, e); else passed++;
        end
        a_start = 1'b1;
        for (int k = 0; k <= 1; k++) exp_q.push_back(model(MODE_CHANGE_RETURN, 3, 1, k));
        for (int k = 0; k <= 1; k++) begin
            cyc();
            a_start = 1'b0;
            e = exp_q.pop_front(); o = obs_a(); checks++;
            if (o !== e) $display("FAIL cfg_new k=%0d got=%h want=%h", k, o, e); else passed++;
        end
        a_cancel = 1'b1;
        exp_q.push_back({MODE_CHANGE_RETURN, 8'd0, 4'b0000});
        cyc();
        a_cancel = 1'b0;
        e = exp_q.pop_front(); o = obs_a(); checks++;
        if (o !== e) $display("FAIL cfg_cancel got=%h want=%h", o, e); else passed++;
    endtask

    task automatic test_restart_cancel();
        a_start = 1'b1; a_start_mode = MODE_WAIT_SELECT;
        for (int k = 0; k <= 18; k++) exp_q.push_back(model(MODE_WAIT_SELECT, 30, 1, k));
        for (int k = 0; k <= 18; k++) begin
            cyc();
            a_start = 1'b0;
            e = exp_q.pop_front(); o = obs_a(); checks++;
            if (o !== e) $display("FAIL run30 k=%0d got=%h want=%h", k, o, e); else passed++;
        end
        a_start = 1'b1; a_start_mode = MODE_PRODUCT_RETURN;
        for (int k = 0; k <= 1; k++) exp_q.push_back(model(MODE_PRODUCT_RETURN, 5, 1, k));
        for (int k = 0; k <= 1; k++) begin
            cyc();
            a_start = 1'b0;
            e = exp_q.pop_front(); o = obs_a(); checks++;
            if (o !== e) $display("FAIL restart k=%0d got=%h want=%h", k, o, e); else passed++;
        end
        a_cancel = 1'b1;
        for (int k = 0; k <= 7; k++) exp_q.push_back({MODE_PRODUCT_RETURN, 8'd0, 4'b0000});
        for (int k = 0; k <= 7; k++) begin
            cyc();
            a_cancel = 1'b0;
            e = exp_q.pop_front(); o = obs_a(); checks++;
            if (o !== e) $display("FAIL cancel k=%0d got=%h want=%h", k, o, e); else passed++;
        end
    endtask

    task automatic test_invalid_mode();
        a_start = 1'b1; a_start_mode = 2'd3;
        exp_q.push_back({MODE_PRODUCT_RETURN, 8'd0, 4'b0001});
        exp_q.push_back({MODE_PRODUCT_RETURN, 8'd0, 4'b0000});
        for (int k = 0; k <= 1; k++) begin
            cyc();
            a_start = 1'b0;
            e = exp_q.pop_front(); o = obs_a(); checks++;
            if (o !== e) $display("FAIL bad_start k=%0d got=%h want=%h", k, o, e); else passed++;
        end
        a_cfg_we = 1'b1; a_cfg_mode = 2'd3; a_cfg_value = 8'd7;
        exp_q.push_back({MODE_PRODUCT_RETURN, 8'd0, 4'b0001});
        cyc();
        a_cfg_we = 1'b0;
        e = exp_q.pop_front(); o = obs_a(); checks++;
        if (o !== e) $display("FAIL bad_cfg got=%h want=%h", o, e); else passed++;
    endtask

    task automatic test_zero_reload();
        a_cfg_we = 1'b1; a_cfg_mode = MODE_PRODUCT_RETURN; a_cfg_value = 8'd0;
        cyc();
        a_cfg_we = 1'b0;
        a_start = 1'b1; a_start_mode = MODE_PRODUCT_RETURN;
        for (int k = 0; k <= 3; k++) exp_q.push_back(model(MODE_PRODUCT_RETURN, 0, 1, k));
        for (int k = 0; k <= 3; k++) begin
            cyc();
            a_start = 1'b0;
            e = exp_q.pop_front(); o = obs_a(); checks++;
            if (o !== e) $display("FAIL zero k=%0d got=%h want=%h", k, o, e); else passed++;
        end
    endtask

    task automatic test_reset_mid_run();
        a_cfg_we = 1'b1; a_cfg_mode = MODE_WAIT_SELECT; a_cfg_value = 8'd99;
        cyc();
        a_cfg_we = 1'b0;
        a_start = 1'b1; a_start_mode = MODE_WAIT_SELECT;
        cyc();
        a_start = 1'b0;
        exp_q.push_back(model(MODE_WAIT_SELECT, 99, 1, 2));
        cyc(); cyc();
        e = exp_q.pop_front(); o = obs_a(); checks++;
        if (o !== e) $display("FAIL pre_rst got=%h want=%h", o, e); else passed++;
        #3 rst = 1'b1;
        #1;
        exp_q.push_back(14'h0);
        exp_q.push_back(14'h0);
        e = exp_q.pop_front(); o = obs_a(); checks++;
        if (o !== e) $display("FAIL async_rst_a got=%h want=%h", o, e); else passed++;
        e = exp_q.pop_front(); o = obs_b(); checks++;
        if (o !== e) $display("FAIL async_rst_b got=%h want=%h", o, e); else passed++;
        #1 rst = 1'b0;
        exp_q.push_back(14'h0);
        cyc();
        e = exp_q.pop_front(); o = obs_a(); checks++;
        if (o !== e) $display("FAIL post_rst got=%h want=%h", o, e); else passed++;
        a_start = 1'b1; a_start_mode = MODE_WAIT_SELECT;
        b_start = 1'b1; b_start_mode = 2'd3;
        exp_q.push_back(model(MODE_WAIT_SELECT, 30, 1, 0));
        exp_q.push_back(model(2'd3, 0, 4, 0));
        cyc();
        b_start = 1'b0;
        e = exp_q.pop_front(); o = obs_a(); checks++;
        if (o !== e) $display("FAIL restore_m0 got=%h want=%h", o, e); else passed++;
        e = exp_q.pop_front(); o = obs_b(); checks++;
        if (o !== e) $display("FAIL restore_b_m3 got=%h want=%h", o, e); else passed++;
        a_start_mode = MODE_PRODUCT_RETURN;
        exp_q.push_back(model(MODE_PRODUCT_RETURN, 5, 1, 0));
        cyc();
        a_start = 1'b0;
        e = exp_q.pop_front(); o = obs_a(); checks++;
        if (o !== e) $display("FAIL restore_m1 got=%h want=%h", o, e); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_start = 1'b0; a_start_mode = '0; a_pause = 1'b0; a_cancel = 1'b0;
        a_cfg_we = 1'b0; a_cfg_mode = '0; a_cfg_value = '0;
        b_start = 1'b0; b_start_mode = '0; b_pause = 1'b0; b_cancel = 1'b0;
        b_cfg_we = 1'b0; b_cfg_mode = '0; b_cfg_value = '0;
        test_reset();
        test_countdown();
        test_prescaler();
        test_pause();
        test_cfg_same_cycle();
        test_restart_cancel();
        test_invalid_mode();
        test_zero_reload();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
